// File: rtl/zube_wb_mailbox_if.sv
// zube_wb_mailbox_if: Wishbone slave pins, host irq and external-bus byte handshakes.
// slave modport = mailbox side, master modport = host/engine side.
interface zube_wb_mailbox_if;
  logic        wb_cyc_in;
  logic        wb_stb_in;
  logic        wb_we_in;
  logic [31:0] wb_addr_in;
  logic [31:0] wb_data_in;
  logic        wb_ack_out;
  logic [31:0] wb_data_out;
  logic        irq_out;
  logic        ext_rd_valid;
  logic [7:0]  ext_rd_data;
  logic        ext_rd_ready;
  logic        ext_wr_valid;
  logic [7:0]  ext_wr_data;
  logic        ext_wr_ready;

  modport slave (
    input  wb_cyc_in, wb_stb_in, wb_we_in,
    input  wb_addr_in, wb_data_in,
    output wb_ack_out, wb_data_out, irq_out,
    output ext_rd_valid, ext_rd_data,
    input  ext_rd_ready,
    input  ext_wr_valid, ext_wr_data,
    output ext_wr_ready
  );

  modport master (
    output wb_cyc_in, wb_stb_in, wb_we_in,
    output wb_addr_in, wb_data_in,
    input  wb_ack_out, wb_data_out, irq_out,
    input  ext_rd_valid, ext_rd_data,
    output ext_rd_ready,
    output ext_wr_valid, ext_wr_data,
    input  ext_wr_ready
  );
endinterface

// File: rtl/zube_wb_mailbox.sv
// zube_wb_mailbox: Wishbone mailbox with TX (host->ext) and RX (ext->host) byte FIFOs.
// Ports: clk, reset_b (async active-low), bus (zube_wb_mailbox_if.slave).
// Regs @ addr[3:2]: 0 DATA, 1 STATUS, 2 IRQ_EN, 3 CONTROL.
// Optional macro ZUBE_MAILBOX_IRQ_EN: adds IRQ_EN register and irq_out.

module zube_wb_mailbox_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [7:0]               head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rp_q];

  // full/empty are sampled before this edge's pop/push
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= data_i;
        wp_q        <= wp_q + AW'(1);
      end
      if (do_pop) rp_q <= rp_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module zube_wb_mailbox #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DEPTH     = 8
) (
  input  logic              clk,
  input  logic              reset_b,
  zube_wb_mailbox_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          ack_q;
  logic [31:0]   data_q;
  logic          ovf_q;
  logic          unf_q;

  logic          hit;
  logic          acc;
  logic [1:0]    sel;
  logic          we;
  logic [31:0]   wdata;

  logic [7:0]    tx_head;
  logic [7:0]    rx_head;
  logic [CW-1:0] tx_cnt;
  logic [CW-1:0] rx_cnt;
  logic          tx_full;
  logic          tx_empty;
  logic          rx_full;
  logic          rx_empty;

  logic          tx_push;
  logic          tx_pop;
  logic          rx_push;
  logic          rx_pop;
  logic          tx_flush;
  logic          rx_flush;
  logic          set_ovf;
  logic          set_unf;
  logic          clr_flags;
  logic          en_we;
  logic [1:0]    en_rd;
  logic [31:0]   status;
  logic [31:0]   rdata_d;

  assign hit   = (bus.wb_addr_in[31:4] == BASE_ADDR[31:4]);
  // ack_q blocks a second access while stb is still held
  assign acc   = bus.wb_cyc_in & bus.wb_stb_in & ~ack_q & hit;
  assign sel   = bus.wb_addr_in[3:2];
  assign we    = bus.wb_we_in;
  assign wdata = bus.wb_data_in;

  assign tx_pop  = bus.ext_rd_ready & ~tx_empty;
  assign rx_push = bus.ext_wr_valid & ~rx_full;

  assign status = {9'd0, 7'(tx_cnt), 1'b0, 7'(rx_cnt), 3'd0,
                   unf_q, ovf_q, tx_empty, tx_full, ~rx_empty};

  always_comb begin
    tx_push   = 1'b0;
    rx_pop    = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    tx_flush  = 1'b0;
    rx_flush  = 1'b0;
    clr_flags = 1'b0;
    en_we     = 1'b0;
    rdata_d   = '0;
    if (acc) begin
      unique case (sel)
        2'd0: begin
          if (we) begin
            if (tx_full) set_ovf = 1'b1;
            else         tx_push = 1'b1;
          end else if (rx_empty) begin
            set_unf = 1'b1;
          end else begin
            rx_pop  = 1'b1;
            rdata_d = {24'd0, rx_head};
          end
        end
        2'd1: begin
          if (!we) rdata_d = status;
        end
        2'd2: begin
          if (we) en_we   = 1'b1;
          else    rdata_d = {30'd0, en_rd};
        end
        2'd3: begin
          if (we) begin
            tx_flush  = wdata[0];
            rx_flush  = wdata[1];
            clr_flags = wdata[2];
          end
        end
      endcase
    end
  end

  zube_wb_mailbox_fifo #(.DEPTH(DEPTH)) u_tx (
    .clk     (clk),
    .reset_b (reset_b),
    .push_i  (tx_push),
    .data_i  (wdata[7:0]),
    .pop_i   (tx_pop),
    .flush_i (tx_flush),
    .head_o  (tx_head),
    .count_o (tx_cnt),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  zube_wb_mailbox_fifo #(.DEPTH(DEPTH)) u_rx (
    .clk     (clk),
    .reset_b (reset_b),
    .push_i  (rx_push),
    .data_i  (bus.ext_wr_data),
    .pop_i   (rx_pop),
    .flush_i (rx_flush),
    .head_o  (rx_head),
    .count_o (rx_cnt),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ack_q  <= 1'b0;
      data_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      ack_q  <= acc;
      data_q <= rdata_d;
      if (clr_flags)    ovf_q <= 1'b0;
      else if (set_ovf) ovf_q <= 1'b1;
      if (clr_flags)    unf_q <= 1'b0;
      else if (set_unf) unf_q <= 1'b1;
    end
  end

`ifdef ZUBE_MAILBOX_IRQ_EN
  logic [1:0] en_q;
  logic       irq_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      en_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      if (en_we) en_q <= wdata[1:0];
      irq_q <= (en_q[0] & ~rx_empty) | (en_q[1] & tx_empty);
    end
  end

  assign en_rd       = en_q;
  assign bus.irq_out = irq_q;

  logic unused;
  assign unused = ^{bus.wb_addr_in[1:0], wdata[31:8]};
`else
  assign en_rd       = 2'b00;
  assign bus.irq_out = 1'b0;

  logic unused;
  assign unused = ^{bus.wb_addr_in[1:0], wdata[31:8], en_we};
`endif

  assign bus.wb_ack_out   = ack_q;
  assign bus.wb_data_out  = data_q;
  assign bus.ext_rd_valid = ~tx_empty;
  assign bus.ext_rd_data  = tx_head;
  assign bus.ext_wr_ready = ~rx_full;
endmodule

// File: tb/tb_zube_wb_mailbox.sv
// tb_zube_wb_mailbox: directed + random bench for zube_wb_mailbox.
// Queue-based reference model stepped once per clock edge.
module tb_zube_wb_mailbox;
  logic clk;
  logic reset_b;

  zube_wb_mailbox_if bus();

  zube_wb_mailbox #(
    .BASE_ADDR (32'h3000_0000),
    .DEPTH     (8)
  ) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  bit          ovf, unf;
  logic [1:0]  en;
  bit          ack_e, irq_e;
  logic [31:0] dat_e;
  logic        obs_ack;
  logic [31:0] obs_data;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, o, e);
    end
  endtask

  function automatic bit hit(input logic [31:0] a);
    return (a >> 4) == (32'h3000_0000 >> 4);
  endfunction

  function automatic logic [31:0] status_m();
    logic [31:0] s;
    s = 32'd0;
    s[0]     = rxq.size() > 0;
    s[1]     = txq.size() == 8;
    s[2]     = txq.size() == 0;
    s[3]     = ovf;
    s[4]     = unf;
    s[14:8]  = 7'(rxq.size());
    s[22:16] = 7'(txq.size());
    return s;
  endfunction

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    ovf = 0; unf = 0; en = 2'b00;
    ack_e = 0; irq_e = 0; dat_e = 32'd0;
  endtask

  // one clock: decide from pre-edge state, apply at edge, compare after
  task automatic tick();
    bit acc, txpop, rxpush, txpush, rxpop, ftx, frx, clr, sovf, sunf, enw, irqn;
    logic [31:0] rd;
    logic [7:0]  txb, rxb;
    logic [1:0]  en_n;
    acc = bus.wb_cyc_in && bus.wb_stb_in && !ack_e && hit(bus.wb_addr_in);
    txpop = 0; rxpush = 0; txpush = 0; rxpop = 0;
    ftx = 0; frx = 0; clr = 0; sovf = 0; sunf = 0; enw = 0;
    rd = 32'd0;
    txb = bus.wb_data_in[7:0];
    rxb = bus.ext_wr_data;
    en_n = bus.wb_data_in[1:0];
    if (txq.size() > 0)
      chk("rd_data", {24'd0, bus.ext_rd_data}, {24'd0, txq[0]});
    txpop  = bus.ext_rd_ready && txq.size() > 0;
    rxpush = bus.ext_wr_valid && rxq.size() < 8;
    if (acc) begin
      case (bus.wb_addr_in[3:2])
        2'd0: begin
          if (bus.wb_we_in) begin
            if (txq.size() < 8) txpush = 1; else sovf = 1;
          end else if (rxq.size() > 0) begin
            rd = {24'd0, rxq[0]};
            rxpop = 1;
          end else sunf = 1;
        end
        2'd1: if (!bus.wb_we_in) rd = status_m();
        2'd2: begin
`ifdef ZUBE_MAILBOX_IRQ_EN
          if (bus.wb_we_in) enw = 1; else rd = {30'd0, en};
`endif
        end
        default: begin
          if (bus.wb_we_in) begin
            ftx = bus.wb_data_in[0];
            frx = bus.wb_data_in[1];
            clr = bus.wb_data_in[2];
          end
        end
      endcase
    end
`ifdef ZUBE_MAILBOX_IRQ_EN
    irqn = (en[0] && rxq.size() > 0) || (en[1] && txq.size() == 0);
`else
    irqn = 0;
`endif
    @(posedge clk);
    if (ftx) txq.delete();
    else begin
      if (txpop) void'(txq.pop_front());
      if (txpush) txq.push_back(txb);
    end
    if (frx) rxq.delete();
    else begin
      if (rxpop) void'(rxq.pop_front());
      if (rxpush) rxq.push_back(rxb);
    end
    if (clr) begin ovf = 0; unf = 0; end
    if (sovf) ovf = 1;
    if (sunf) unf = 1;
    if (enw) en = en_n;
    ack_e = acc;
    dat_e = rd;
    irq_e = irqn;
    #1;
    obs_ack  = bus.wb_ack_out;
    obs_data = bus.wb_data_out;
    chk("ack", {31'd0, obs_ack}, {31'd0, ack_e});
    chk("rdata", obs_data, dat_e);
    chk("rd_valid", {31'd0, bus.ext_rd_valid}, {31'd0, txq.size() > 0});
    chk("wr_ready", {31'd0, bus.ext_wr_ready}, {31'd0, rxq.size() < 8});
    chk("irq", {31'd0, bus.irq_out}, {31'd0, irq_e});
    @(negedge clk);
  endtask

  task automatic wb(input bit w, input logic [1:0] r, input logic [31:0] d);
    int n;
    bus.wb_cyc_in  = 1;
    bus.wb_stb_in  = 1;
    bus.wb_we_in   = w;
    bus.wb_addr_in = 32'h3000_0000 | {28'd0, r, 2'b00};
    bus.wb_data_in = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (obs_ack !== 1'b1 && n < 4);
    if (obs_ack !== 1'b1) chk("ack_timeout", {31'd0, obs_ack}, 32'd1);
    bus.wb_cyc_in = 0;
    bus.wb_stb_in = 0;
    bus.wb_we_in  = 0;
  endtask

  initial begin
    logic [7:0] b;
    reset_b = 0;
    bus.wb_cyc_in = 0; bus.wb_stb_in = 0; bus.wb_we_in = 0;
    bus.wb_addr_in = 32'd0; bus.wb_data_in = 32'd0;
    bus.ext_rd_ready = 0; bus.ext_wr_valid = 0; bus.ext_wr_data = 8'd0;
    model_reset();
    obs_ack = 0; obs_data = 0;
    repeat (2) @(negedge clk);
    chk("rst_ack", {31'd0, bus.wb_ack_out}, 32'd0);
    chk("rst_data", bus.wb_data_out, 32'd0);
    chk("rst_irq", {31'd0, bus.irq_out}, 32'd0);
    chk("rst_rd_valid", {31'd0, bus.ext_rd_valid}, 32'd0);
    chk("rst_wr_ready", {31'd0, bus.ext_wr_ready}, 32'd1);
    reset_b = 1;
    tick();
    wb(0, 1, 0);
    chk("status_after_rst", obs_data, 32'h0000_0004);

    // reset in the middle of an ack
    tick();
    bus.wb_cyc_in = 1; bus.wb_stb_in = 1; bus.wb_we_in = 1;
    bus.wb_addr_in = 32'h3000_0000; bus.wb_data_in = 32'h77;
    @(posedge clk);
    #1;
    chk("ack_before_rst", {31'd0, bus.wb_ack_out}, 32'd1);
    reset_b = 0;
    #1;
    chk("ack_async_rst", {31'd0, bus.wb_ack_out}, 32'd0);
    chk("rd_valid_async_rst", {31'd0, bus.ext_rd_valid}, 32'd0);
    model_reset();
    bus.wb_cyc_in = 0; bus.wb_stb_in = 0; bus.wb_we_in = 0;
    @(negedge clk);
    reset_b = 1;
    tick();
    wb(0, 1, 0);
    chk("status_after_rst2", obs_data, 32'h0000_0004);
    chk("wr_ready_after_rst", {31'd0, bus.ext_wr_ready}, 32'd1);

    // TX overflow and drain
    for (int i = 0; i < 9; i++) wb(1, 0, 32'h11 + i);
    wb(0, 1, 0);
    chk("tx_ovf_status", obs_data, 32'h0008_000A);
    bus.ext_rd_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", {31'd0, bus.ext_rd_valid}, 32'd1);
      chk("drain_data", {24'd0, bus.ext_rd_data}, 32'h11 + i);
      tick();
    end
    chk("drain_empty", {31'd0, bus.ext_rd_valid}, 32'd0);
    bus.ext_rd_ready = 0;
    wb(1, 3, 32'h4);

    // RX fill and underflow
    bus.ext_wr_valid = 1;
    bus.ext_wr_data = 8'hA5; tick();
    chk("rx_ready1", {31'd0, bus.ext_wr_ready}, 32'd1);
    bus.ext_wr_data = 8'h5A; tick();
    chk("rx_ready2", {31'd0, bus.ext_wr_ready}, 32'd1);
    bus.ext_wr_valid = 0;
    wb(0, 0, 0); chk("rx_rd_a5", obs_data, 32'h0000_00A5);
    wb(0, 0, 0); chk("rx_rd_5a", obs_data, 32'h0000_005A);
    wb(0, 0, 0); chk("rx_rd_empty", obs_data, 32'h0);
    wb(0, 1, 0); chk("rx_unf_status", obs_data, 32'h0000_0014);
    wb(1, 3, 32'h4);

    // RX full boundary
    bus.ext_wr_valid = 1;
    for (int i = 0; i < 9; i++) begin
      bus.ext_wr_data = 8'(8'hC0 + i);
      tick();
    end
    bus.ext_wr_valid = 0;
    chk("rx_full_ready", {31'd0, bus.ext_wr_ready}, 32'd0);
    wb(0, 1, 0); chk("rx_full_status", obs_data, 32'h0000_0805);
    wb(0, 0, 0); chk("rx_full_head", obs_data, 32'h0000_00C0);
    wb(1, 3, 32'h7);

    // full TX: write and ext pop on the same edge
    for (int i = 0; i < 8; i++) wb(1, 0, 32'h21 + i);
    tick();
    bus.ext_rd_ready = 1;
    wb(1, 0, 32'h99);
    bus.ext_rd_ready = 0;
    wb(0, 1, 0);
    chk("full_push_pop", obs_data, 32'h0007_0008);

    // 3 entries: push and pop on the same edge
    wb(1, 3, 32'h5);
    for (int i = 0; i < 3; i++) wb(1, 0, 32'h31 + i);
    tick();
    bus.ext_rd_ready = 1;
    wb(1, 0, 32'h44);
    bus.ext_rd_ready = 0;
    wb(0, 1, 0);
    chk("push_pop_3", obs_data, 32'h0003_0000);
    chk("push_pop_head", {24'd0, bus.ext_rd_data}, 32'h32);
    wb(1, 3, 32'h7);

    // RX pointer wrap
    for (int i = 0; i < 20; i++) begin
      b = 8'(i * 7 + 3);
      bus.ext_wr_valid = 1;
      bus.ext_wr_data = b;
      tick();
      bus.ext_wr_valid = 0;
      wb(0, 0, 0);
      chk("wrap_data", obs_data, {24'd0, b});
    end

    // out-of-decode access is never acked
    bus.wb_cyc_in = 1; bus.wb_stb_in = 1; bus.wb_we_in = 1;
    bus.wb_addr_in = 32'h3000_0010; bus.wb_data_in = 32'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_ack_outside", {31'd0, obs_ack}, 32'd0);
    end
    bus.wb_cyc_in = 0; bus.wb_stb_in = 0; bus.wb_we_in = 0;
    wb(1, 1, 32'hFFFF_FFFF);
    wb(0, 1, 0);
    chk("outside_status", obs_data, 32'h0000_0004);

`ifdef ZUBE_MAILBOX_IRQ_EN
    wb(1, 2, 32'h1);
    wb(0, 2, 0); chk("irq_en_rd", obs_data, 32'h1);
    tick();
    bus.ext_wr_valid = 1; bus.ext_wr_data = 8'h3C;
    tick();
    bus.ext_wr_valid = 0;
    chk("irq_not_yet", {31'd0, bus.irq_out}, 32'd0);
    tick();
    chk("irq_rise", {31'd0, bus.irq_out}, 32'd1);
    wb(0, 0, 0); chk("irq_pop_data", obs_data, 32'h3C);
    tick();
    chk("irq_fall", {31'd0, bus.irq_out}, 32'd0);
    wb(1, 2, 32'h2);
    tick();
    chk("irq_tx_empty", {31'd0, bus.irq_out}, 32'd1);
    wb(1, 0, 32'h10);
    tick(); tick();
    chk("irq_tx_busy", {31'd0, bus.irq_out}, 32'd0);
    wb(1, 2, 32'h0);
`else
    wb(1, 2, 32'h3);
    wb(0, 2, 0); chk("irq_en_absent", obs_data, 32'h0);
    bus.ext_wr_valid = 1; bus.ext_wr_data = 8'h3C;
    tick();
    bus.ext_wr_valid = 0;
    tick(); tick();
    chk("irq_tied_low", {31'd0, bus.irq_out}, 32'd0);
`endif

    // CONTROL=3 flushes both FIFOs
    wb(1, 0, 32'h66);
    bus.ext_wr_valid = 1; bus.ext_wr_data = 8'h77;
    tick();
    bus.ext_wr_valid = 0;
    wb(1, 3, 32'h3);
    wb(0, 1, 0);
    chk("flush_both", obs_data, 32'h0000_0004);

    // random traffic against the model
`ifdef ZUBE_MAILBOX_IRQ_EN
    wb(1, 2, 32'h3);
`endif
    for (int c = 0; c < 1500; c++) begin
      int r;
      bus.wb_cyc_in = 1'($urandom_range(0, 3) != 0);
      bus.wb_stb_in = bus.wb_cyc_in & 1'($urandom_range(0, 1));
      bus.wb_we_in  = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 15);
      bus.wb_data_in = $urandom;
      if (r < 6)       bus.wb_addr_in = 32'h3000_0000;
      else if (r < 10) bus.wb_addr_in = 32'h3000_0004;
      else if (r < 12) bus.wb_addr_in = 32'h3000_0008;
      else if (r < 14) begin
        bus.wb_addr_in = 32'h3000_000C;
        if ($urandom_range(0, 5) != 0) bus.wb_data_in = bus.wb_data_in & 32'h4;
      end
      else if (r < 15) bus.wb_addr_in = 32'h3000_0000 | ($urandom & 32'hF);
      else             bus.wb_addr_in = 32'h3000_0100 | ($urandom & 32'hF);
      bus.ext_rd_ready = 1'($urandom_range(0, 2) == 0);
      bus.ext_wr_valid = 1'($urandom_range(0, 1));
      bus.ext_wr_data  = 8'($urandom);
      tick();
    end
    bus.wb_cyc_in = 0; bus.wb_stb_in = 0; bus.wb_we_in = 0;
    bus.ext_rd_ready = 0; bus.ext_wr_valid = 0;
    tick();
    wb(0, 1, 0);
    chk("final_status", obs_data, status_m());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/zube_wb_mailbox.md
# zube_wb_mailbox

Wishbone-slave mailbox between the Caravel management SoC and the Zube external-bus engine. It holds two byte-wide FIFOs: TX carries host to external bus, RX carries external bus to host. It sits directly behind the Wishbone pins of `zube_wrapper` and drives `wb_ack_out`, `wb_data_out` and `irq_out`. The external-bus engine drains TX and fills RX through valid/ready handshakes.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h3000_0000: Wishbone base; block decodes `wb_addr_in[31:4] == BASE_ADDR[31:4]`.
- `DEPTH`, default 8: entries per FIFO; power of two, 2..64.

Ports:
- `clk` in 1: single clock (Wishbone clock).
- `reset_b` in 1: asynchronous, active-low reset.
- `wb_cyc_in`, `wb_stb_in`, `wb_we_in` in 1 each: Wishbone classic cycle, strobe and write-enable.
- `wb_addr_in` in 32, `wb_data_in` in 32: Wishbone address and write data.
- `wb_ack_out` out 1: Wishbone acknowledge.
- `wb_data_out` out 32: Wishbone read data.
- `irq_out` out 1: level interrupt to host.
- `ext_rd_valid` out 1, `ext_rd_data` out 8, `ext_rd_ready` in 1: TX FIFO head offered to the external-bus engine.
- `ext_wr_valid` in 1, `ext_wr_data` in 8, `ext_wr_ready` out 1: bytes pushed into the RX FIFO.

## Operation
Registers, selected by `wb_addr_in[3:2]`:
- 0 DATA
  - Write pushes `wb_data_in[7:0]` to TX. If TX is full, the byte is dropped and sticky `tx_ovf` is set.
  - Read pops RX and returns the byte zero-extended. If RX is empty, the read returns 0, there is no pop, and sticky `rx_unf` is set.
- 1 STATUS (RO)
  - [0] rx_nonempty, [1] tx_full, [2] tx_empty, [3] tx_ovf, [4] rx_unf.
  - [14:8] rx_count, [22:16] tx_count.
  - Writes are ignored.
- 2 IRQ_EN (RW)
  - [0] enables irq on rx_nonempty; [1] enables irq on tx_empty.
  - Other bits read 0.
- 3 CONTROL (WO, reads 0)
  - Write bit0=1 flushes TX; bit1=1 flushes RX.
  - Bit2=1 clears `tx_ovf` and `rx_unf`.

FIFO behaviour:
- Circular buffers with `$clog2(DEPTH)`-bit pointers that wrap modulo DEPTH, plus a `$clog2(DEPTH)+1`-bit count.
- full means count==DEPTH; empty means count==0.
- Push and pop in the same cycle leave count unchanged and both take effect.
- Full is evaluated before a same-cycle pop, so a push to a full FIFO is dropped even if a pop occurs that cycle.
- A flush takes priority over any same-cycle push or pop: count=0 and pointers=0.

Handshakes:
- `ext_rd_valid` = !tx_empty and `ext_rd_data` = TX head, both combinational from storage. A pop occurs when `ext_rd_valid & ext_rd_ready`.
- `ext_wr_ready` = !rx_full. A push occurs when `ext_wr_valid & ext_wr_ready`.
- A Wishbone access outside the block's address decode is ignored and never acked.

## Timing
- Reset values: `wb_ack_out`=0, `wb_data_out`=0, `irq_out`=0, `ext_rd_valid`=0, `ext_wr_ready`=1.
- Reset also zeroes FIFOs, pointers, IRQ_EN and the sticky flags.
- Reset asserted mid-transaction aborts it immediately: ack drops with no clock edge required.
- Wishbone access:
  - `wb_ack_out` rises on the edge after `cyc & stb & !ack & decode`, and is high for exactly one cycle.
  - The register side effect (push, pop, write) commits on that same edge.
  - `wb_data_out` is registered with ack and returns to 0 when ack is low.
  - With stb held, back-to-back accesses run on alternate cycles.
- TX latency: a DATA write raises `ext_rd_valid` on the ack edge (0 cycles after ack).
- RX latency: an ext push is visible in STATUS and DATA to an access whose ack edge is the following edge or later.
- `irq_out` is registered: `(irq_en[0] & rx_nonempty) | (irq_en[1] & tx_empty)`, one cycle after the condition.

## Configuration
- `ZUBE_MAILBOX_IRQ_EN` defined: IRQ_EN register and `irq_out` logic are present as described above.
- `ZUBE_MAILBOX_IRQ_EN` undefined:
  - `irq_out` is tied 0.
  - IRQ_EN reads 0 and ignores writes.
  - All other behaviour is identical.

## Test plan
- Reset checks:
  - Assert `reset_b`=0 mid-ack: ack=0 asynchronously.
  - After release: STATUS reads 0x0000_0004 and `ext_wr_ready`=1.
- TX overflow (DEPTH=8):
  - Write DATA 0x11..0x19 (9 writes).
  - STATUS shows tx_count=8, tx_full=1, tx_ovf=1.
  - With `ext_rd_ready`=1, the engine sees 0x11..0x18 in order, then `ext_rd_valid`=0.
- RX fill and underflow:
  - Ext pushes 0xA5, 0x5A: `ext_wr_ready` stays 1.
  - DATA reads return 0x000000A5, then 0x0000005A, then 0 with rx_unf=1.
- Simultaneous TX activity:
  - TX full, Wishbone DATA write and ext pop in the same cycle: byte dropped, count becomes 7, tx_ovf=1.
  - TX at 3 entries, push and pop in the same cycle: count stays 3.
- Pointer wrap: push and pop 20 bytes through RX one at a time; the data sequence is preserved across pointer wrap.
- IRQ (macro on):
  - IRQ_EN=1 and an ext push: `irq_out` rises one cycle later.
  - Popping the byte: `irq_out` falls.
  - CONTROL=0x3 flushes both FIFOs.
  - Macro off: `irq_out` stays 0 throughout.
